// File: rtl/seq_addsub_if.sv
// ==========================================================================
// seq_addsub_if : operand/result handshake bundle for seq_addsub
// Revision      : 1.0
// ==========================================================================
`default_nettype none

interface seq_addsub_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [IMM_W-1:0] imm;
  logic             use_imm;
  logic             imm_sext;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, imm, use_imm, imm_sext, sub, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, imm, use_imm, imm_sext, sub, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_addsub.sv
// ==========================================================================
// seq_addsub : multi-cycle adder/subtractor, CHUNK bits per clock via a registered carry
// Revision   : 1.0
// ==========================================================================
`default_nettype none

module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int IMM_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_addsub_if.slave bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [N-1:0][CHUNK-1:0] r_a;
  logic [N-1:0][CHUNK-1:0] r_bx;
  logic [N-1:0][CHUNK-1:0] r_result;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_carry;
  logic                    r_cout;
  logic                    r_ovf;
  logic                    r_zero;

  logic [WIDTH-1:0]        w_imm_ext;
  logic [WIDTH-1:0]        w_bsel;
  logic [CHUNK:0]          w_chunk_sum;
  logic [N-1:0][CHUNK-1:0] w_result_next;
  logic                    w_ovf_next;
  logic                    w_zero_next;
  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_accept;
  logic                    w_step;
  logic                    w_finish;

  generate
    if (IMM_W == WIDTH) begin : g_imm_full
      assign w_imm_ext = bus.imm;
    end else begin : g_imm_ext
      assign w_imm_ext = {{(WIDTH-IMM_W){bus.imm_sext & bus.imm[IMM_W-1]}}, bus.imm};
    end
  endgenerate

  assign w_bsel = bus.use_imm ? w_imm_ext : bus.b;

  // One chunk per cycle; flags are taken from the result as it will be after this edge
  always_comb begin
    w_chunk_sum          = {1'b0, r_a[r_idx]} + {1'b0, r_bx[r_idx]} + {{CHUNK{1'b0}}, r_carry};
    w_result_next        = r_result;
    w_result_next[r_idx] = w_chunk_sum[CHUNK-1:0];
    w_ovf_next           = (r_a[N-1][CHUNK-1] == r_bx[N-1][CHUNK-1]) &&
                           (w_result_next[N-1][CHUNK-1] != r_a[N-1][CHUNK-1]);
    w_zero_next          = (w_result_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_finish     = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Subtraction is A + ~B' + 1, the +1 entering as the initial carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_bx     <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_bx    <= bus.sub ? ~w_bsel : w_bsel;
      r_carry <= bus.sub;
      r_idx   <= '0;
    end else if (w_step) begin
      r_result <= w_result_next;
      r_carry  <= w_chunk_sum[CHUNK];
      if (w_finish) begin
        r_idx  <= '0;
        r_cout <= w_chunk_sum[CHUNK];
        r_ovf  <= w_ovf_next;
        r_zero <= w_zero_next;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = r_result;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_seq_addsub.sv
// ==========================================================================
// tb_seq_addsub : directed and random checks of seq_addsub against an arithmetic model
// Revision      : 1.0
// ==========================================================================
`default_nettype none

module tb_seq_addsub;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t e_cur;

  seq_addsub_if #(.WIDTH(32), .IMM_W(16)) bus ();

  seq_addsub #(.WIDTH(32), .CHUNK(8), .IMM_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Overflow is detected as the wrapped result differing from the exact signed value
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [15:0] imm, input logic ui,
                                 input logic sx, input logic sb);
    exp_t        e;
    logic [31:0] bp;
    logic [32:0] full;
    longint      sa;
    longint      sbv;
    longint      tr;
    bp  = ui ? (sx ? 32'(int'($signed(imm))) : 32'(imm)) : b;
    sa  = longint'($signed(a));
    sbv = longint'($signed(bp));
    if (sb) begin
      e.res = a - bp;
      e.c   = (a >= bp);
      tr    = sa - sbv;
    end else begin
      full  = {1'b0, a} + {1'b0, bp};
      e.res = full[31:0];
      e.c   = full[32];
      tr    = sa + sbv;
    end
    e.v = (tr != longint'($signed(e.res)));
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                       input logic ui, input logic sx, input logic sb, input string tag);
    int edges;
    e_cur = model(a, b, imm, ui, sx, sb);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.imm      = imm;
    bus.use_imm  = ui;
    bus.imm_sext = sx;
    bus.sub      = sb;
    bus.in_valid = 1'b1;
    check({tag, "/in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.imm      = 16'($urandom);
    bus.use_imm  = ~ui;
    bus.imm_sext = ~sx;
    bus.sub      = ~sb;
    check({tag, "/in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 16) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "/latency"}, 64'(edges), 64'd4);
  endtask

  task automatic check_result(input string tag);
    check({tag, "/result"}, 64'(bus.result), 64'(e_cur.res));
    check({tag, "/cout"},   64'(bus.cout),   64'(e_cur.c));
    check({tag, "/ovf"},    64'(bus.ovf),    64'(e_cur.v));
    check({tag, "/zero"},   64'(bus.zero),   64'(e_cur.z));
  endtask

  task automatic complete(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "/out_valid_after"}, 64'(bus.out_valid), 64'd0);
    check({tag, "/in_ready_after"},  64'(bus.in_ready),  64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/result"},    64'(bus.result),    64'd0);
    check({tag, "/cout"},      64'(bus.cout),      64'd0);
    check({tag, "/ovf"},       64'(bus.ovf),       64'd0);
    check({tag, "/zero"},      64'(bus.zero),      64'd0);
    check({tag, "/out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "/in_ready"},  64'(bus.in_ready),  64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [15:0] rimm;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.imm       = '0;
    bus.use_imm   = 1'b0;
    bus.imm_sext  = 1'b0;
    bus.sub       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h0000FFFF, 32'h00000001, 16'h0, 1'b0, 1'b0, 1'b0, "add_carry_chain");
    check_result("add_carry_chain");
    check("add_carry_chain/literal", 64'(bus.result), 64'h00010000);
    complete("add_carry_chain");

    issue(32'd5, 32'd5, 16'h0, 1'b0, 1'b0, 1'b1, "sub_equal");
    check_result("sub_equal");
    check("sub_equal/zero_literal", 64'(bus.zero), 64'd1);
    complete("sub_equal");

    issue(32'd0, 32'd1, 16'h0, 1'b0, 1'b0, 1'b1, "sub_borrow");
    check_result("sub_borrow");
    check("sub_borrow/literal", 64'(bus.result), 64'hFFFFFFFF);
    complete("sub_borrow");

    issue(32'h7FFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0, 1'b0, "add_ovf");
    check_result("add_ovf");
    check("add_ovf/ovf_literal", 64'(bus.ovf), 64'd1);
    complete("add_ovf");

    issue(32'hFFFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0, 1'b0, "add_wrap");
    check_result("add_wrap");
    complete("add_wrap");

    issue(32'd0, 32'hDEADBEEF, 16'h8000, 1'b1, 1'b1, 1'b0, "imm_sext");
    check_result("imm_sext");
    check("imm_sext/literal", 64'(bus.result), 64'hFFFF8000);
    complete("imm_sext");

    issue(32'd0, 32'hDEADBEEF, 16'h8000, 1'b1, 1'b0, 1'b0, "imm_zext");
    check_result("imm_zext");
    check("imm_zext/literal", 64'(bus.result), 64'h00008000);
    complete("imm_zext");

    issue(32'h10, 32'hDEADBEEF, 16'h8000, 1'b1, 1'b1, 1'b1, "imm_sub_sext");
    check_result("imm_sub_sext");
    check("imm_sub_sext/literal", 64'(bus.result), 64'h00008010);

    // Hold the result in DONE while a new request is presented
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 32'h12345678;
    bus.b        = 32'h11111111;
    bus.use_imm  = 1'b0;
    bus.sub      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_result($sformatf("hold%0d", i));
      check($sformatf("hold%0d/out_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("hold%0d/in_ready", i),  64'(bus.in_ready),  64'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    complete("hold");

    issue(32'h12345678, 32'h11111111, 16'h0, 1'b0, 1'b0, 1'b1, "after_hold");
    check_result("after_hold");
    complete("after_hold");

    // Reset in the middle of RUN with chunk index 2
    @(negedge clk);
    bus.a        = 32'h11223344;
    bus.b        = 32'h01010101;
    bus.use_imm  = 1'b0;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd1, 32'd2, 16'h0, 1'b0, 1'b0, 1'b0, "post_reset");
    check_result("post_reset");
    check("post_reset/literal", 64'(bus.result), 64'd3);
    complete("post_reset");

    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rimm = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFFFFFF;
        1: ra = 32'h80000000;
        2: rb = ra;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      issue(ra, rb, rimm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      check_result($sformatf("rand%0d", i));
      complete($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
